// File: rtl/quad_enc_emulator.sv
// PmodENC-style quadrature/pushbutton waveform generator with a signed detent
// position tracker, used to exercise the encoder decode path in self-test.
module quad_enc_emulator #(
  parameter int PHASE_CYCLES = 4,
  parameter int PRESS_CYCLES = 16,
  parameter int CNT_W        = 4,
  parameter int POS_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic             btn_req,
  output logic             enc_a,
  output logic             enc_b,
  output logic             enc_sw,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] pos
);

  localparam int MAXC = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam logic [TW-1:0] PH_LAST = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] PR_LAST = TW'(PRESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       ph_q, ph_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
  logic             sw_q, sw_d;
  logic [TW-1:0]    btmr_q, btmr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      ph_q    <= '0;
      tmr_q   <= '0;
      pos_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sw_q    <= 1'b0;
      btmr_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      ph_q    <= ph_d;
      tmr_q   <= tmr_d;
      pos_q   <= pos_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sw_q    <= sw_d;
      btmr_q  <= btmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    ph_d    = ph_q;
    tmr_d   = tmr_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          state_d = RUN;
          dir_d   = dir;
          rem_d   = count;
          ph_d    = '0;
          tmr_d   = '0;
        end
      end
      RUN: begin
        if (tmr_q == PH_LAST) begin
          tmr_d = '0;
          ph_d  = ph_q + 2'd1;
          // Final 00 hold of a detent: commit the position step here only.
          if (ph_q == 2'd3) begin
            pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = FIN;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
    if (state_d == RUN) begin
      case (ph_d)
        2'd0:    {a_d, b_d} = dir_d ? 2'b10 : 2'b01;
        2'd1:    {a_d, b_d} = 2'b11;
        2'd2:    {a_d, b_d} = dir_d ? 2'b01 : 2'b10;
        default: {a_d, b_d} = 2'b00;
      endcase
    end
  end

  always_comb begin
    sw_d   = sw_q;
    btmr_d = btmr_q;
    if (!sw_q) begin
      if (btn_req) begin
        sw_d   = 1'b1;
        btmr_d = '0;
      end
    end else if (btmr_q == PR_LAST) begin
      sw_d = 1'b0;
    end else begin
      btmr_d = btmr_q + TW'(1);
    end
  end

  assign enc_a  = a_q;
  assign enc_b  = b_q;
  assign enc_sw = sw_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pos    = pos_q;

endmodule

// File: tb/tb_quad_enc_emulator.sv
// Scoreboard bench for quad_enc_emulator: per-cycle expected outputs are queued
// when a command is driven and compared on the falling clock edge.
module tb_quad_enc_emulator;

  localparam int PH = 4;
  localparam int PR = 16;
  localparam int CW = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] count = '0;
  logic          btn_req = 1'b0;
  logic          enc_a, enc_b, enc_sw, busy, done;
  logic [PW-1:0] pos;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          a;
    logic          b;
    logic          sw;
    logic          busy;
    logic          done;
    logic [PW-1:0] pos;
  } exp_t;

  exp_t          sb[$];
  bit            swq[$];
  logic [PW-1:0] exp_pos = '0;
  logic [1:0]    prev_ab = 2'b00;

  always #5 clk = ~clk;

  quad_enc_emulator #(
    .PHASE_CYCLES(PH),
    .PRESS_CYCLES(PR),
    .CNT_W(CW),
    .POS_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .count(count),
    .btn_req(btn_req), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .busy(busy), .done(done), .pos(pos)
  );

  function automatic exp_t obs();
    exp_t o;
    o.a = enc_a; o.b = enc_b; o.sw = enc_sw; o.busy = busy; o.done = done; o.pos = pos;
    return o;
  endfunction

  // Gray property on every A/B change while out of reset.
  always @(negedge clk) begin
    if (rst_n && ({enc_a, enc_b} !== prev_ab)) begin
      n_tests++;
      if ($countones({enc_a, enc_b} ^ prev_ab) != 1) begin
        n_fail++;
        $display("FAIL gray: ab %b -> %b, required a one-bit change", prev_ab, {enc_a, enc_b});
      end
    end
    prev_ab = {enc_a, enc_b};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_pos = '0;
  endtask

  task automatic run_cmd(input logic d, input int n, input bit poke, input bit btn, input string name);
    logic [1:0] seq[4];
    exp_t e;
    int idx;
    if (d) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else   seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    @(negedge clk);
    start = 1'b1; dir = d; count = CW'(n); btn_req = btn;
    idx = 0;
    if (n == 0) begin
      repeat (4) begin
        e = '0; e.pos = exp_pos; sb.push_back(e);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int s = 0; s < 4; s++)
          for (int p = 0; p < PH; p++) begin
            e.a = seq[s][1]; e.b = seq[s][0]; e.sw = btn && (idx < PR);
            e.busy = 1'b1; e.done = 1'b0; e.pos = exp_pos;
            sb.push_back(e); idx++;
          end
        exp_pos = d ? exp_pos + PW'(1) : exp_pos - PW'(1);
      end
      e = '0; e.sw = btn && (idx < PR); e.done = 1'b1; e.pos = exp_pos;
      sb.push_back(e); idx++;
      e = '0; e.sw = btn && (idx < PR); e.pos = exp_pos;
      sb.push_back(e);
    end
    idx = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got a%b b%b sw%b busy%b done%b pos=%h, required a%b b%b sw%b busy%b done%b pos=%h",
                 name, idx, enc_a, enc_b, enc_sw, busy, done, pos,
                 e.a, e.b, e.sw, e.busy, e.done, e.pos);
      end
      start = 1'b0; btn_req = 1'b0;
      if (poke && (idx == 5 || e.done)) begin
        start = 1'b1; dir = ~d; count = CW'(7);
      end
      idx++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs() !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h, required %h", obs(), exp_t'(0));
    end
    #1 rst_n = 1'b1;
    exp_pos = '0;
  endtask

  task automatic test_cw_single();
    run_cmd(1'b1, 1, 1'b0, 1'b0, "cw1");
  endtask

  task automatic test_ccw_multi();
    do_reset();
    run_cmd(1'b0, 3, 1'b0, 1'b0, "ccw3");
    n_tests++;
    if (pos !== 8'hFD) begin
      n_fail++;
      $display("FAIL ccw3_pos: got %h, required fd", pos);
    end
  endtask

  task automatic test_zero_and_ignore();
    run_cmd(1'b1, 0, 1'b0, 1'b0, "count0");
    run_cmd(1'b1, 2, 1'b1, 1'b0, "start_ignored");
  endtask

  task automatic test_button();
    @(negedge clk);
    btn_req = 1'b1;
    for (int j = 0; j < 20; j++) swq.push_back(j < PR);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      btn_req = 1'b0;
      n_tests++;
      if (enc_sw !== swq.pop_front()) begin
        n_fail++;
        $display("FAIL btn_pulse[%0d]: got sw=%b, required %b", j, enc_sw, j < PR);
      end
    end
    @(negedge clk);
    btn_req = 1'b1;
    for (int j = 0; j < 60; j++) swq.push_back(((j % (PR + 1)) < PR) && (j < 51));
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == 39) btn_req = 1'b0;
      n_tests++;
      if (enc_sw !== swq.pop_front()) begin
        n_fail++;
        $display("FAIL btn_held[%0d]: got sw=%b, required %b", j, enc_sw, ((j % (PR + 1)) < PR) && (j < 51));
      end
    end
  endtask

  task automatic test_concurrent();
    run_cmd(1'b0, 2, 1'b0, 1'b1, "concurrent");
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (8) run_cmd(1'b1, 15, 1'b0, 1'b0, "preload");
    run_cmd(1'b1, 7, 1'b0, 1'b0, "preload7");
    n_tests++;
    if (pos !== 8'h7F) begin
      n_fail++;
      $display("FAIL preload_pos: got %h, required 7f", pos);
    end
    run_cmd(1'b1, 1, 1'b0, 1'b0, "wrap");
    n_tests++;
    if (pos !== 8'h80) begin
      n_fail++;
      $display("FAIL wrap_pos: got %h, required 80", pos);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    @(negedge clk);
    start = 1'b1; dir = 1'b1; count = CW'(2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if ({enc_a, enc_b} === 2'b11) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_state11: got ab=%b, required 11 within 20 cycles", {enc_a, enc_b});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required %h", obs(), exp_t'(0));
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_pos = '0;
    run_cmd(1'b1, 1, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_cw_single();
    test_ccw_multi();
    test_zero_and_ignore();
    test_button();
    test_concurrent();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
